// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction fetch front end.
// Issues one memory request at a time. Each fetched word is held for decode
// until it is accepted. Branch, jump and trap redirects are handled in every
// phase, and a response that belongs to a redirected-away fetch is dropped.
//
// Handshakes:
//   Memory side: imem_req/imem_addr stay asserted and stable until imem_gnt,
//   except when a redirect replaces the address. After a grant exactly one
//   imem_rvalid beat returns, no earlier than the cycle after the grant.
//   Decode side: id_valid/id_instr/id_pc/id_compressed stay stable while
//   id_ready=0. A transfer happens on a cycle with id_valid=1 and id_ready=1,
//   unless a redirect arrives in the same cycle; the redirect wins and the word
//   is dropped.
module pc_fetch_unit #(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          C_EXT        = 1
) (
  input  logic            clk,
  input  logic            arstn,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_compressed,
  output logic [31:0]     fetch_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  // PCs are halfword aligned, so bit 0 of every loaded address is cleared.
  localparam logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VECTOR & 32'hFFFF_FFFE);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;         // address of the current or next fetch
  logic            flush_q, flush_d;   // the outstanding response must be dropped
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] idpc_q, idpc_d;
  logic            comp_q, comp_d;

  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] next_pc;
  logic            rdata_comp;

  assign target_aligned = redirect_target & ~XLEN'(1);
  assign rdata_comp     = (C_EXT == 1) && (imem_rdata[1:0] != 2'b11);
  assign next_pc        = idpc_q + (comp_q ? XLEN'(2) : XLEN'(4));

  // Next-state logic: FSM transitions, PC selection and capture of the held instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    idpc_d  = idpc_q;
    comp_d  = comp_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = target_aligned;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = target_aligned;
          // A grant in the same cycle went out for the old address, so its
          // response is still owed and must be dropped.
          if (imem_gnt) begin
            state_d = S_WAIT;
            flush_d = 1'b1;
          end
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) begin
            pc_d    = target_aligned;
            flush_d = 1'b0;
            state_d = S_REQ;
          end else if (flush_q) begin
            // pc_q already holds the latest redirect target.
            flush_d = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = imem_rdata;
            idpc_d  = pc_q;
            comp_d  = rdata_comp;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          // The response for the old address is still in flight; the last redirect wins.
          pc_d    = target_aligned;
          flush_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = target_aligned;
          state_d = S_REQ;
        end else if (id_ready) begin
          pc_d    = next_pc;
          cnt_d   = cnt_q + 32'd1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      cnt_q   <= 32'd0;
      instr_q <= 32'd0;
      idpc_q  <= '0;
      comp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      idpc_q  <= idpc_d;
      comp_q  <= comp_d;
    end
  end

  assign imem_req      = (state_q == S_REQ);
  assign imem_addr     = pc_q;
  assign id_valid      = (state_q == S_HOLD);
  assign id_instr      = instr_q;
  assign id_pc         = idpc_q;
  assign id_compressed = comp_q;
  assign fetch_cnt     = cnt_q;

endmodule
